cfs_apb_master: RTL and testbench

APB initiator (master) that converts a simple valid/ready request channel into compliant APB3 transfers (setup phase, then access phase with wait states). It returns read data and error status on a valid/ready response channel. It sits between an internal command source (sequencer model, test CPU, bridge) and the APB bus, on the opposite end of the APB interface from the slave and checker. Transfers are strictly one at a time, with an optional access-phase timeout.

---
 rtl/cfs_apb_master_pkg.sv | 34 +++
 rtl/cfs_apb_master_if.sv | 55 +++++
 rtl/cfs_apb_master_timer.sv | 40 ++++
 rtl/cfs_apb_master.sv | 133 +++++++++++++
 tb/tb_cfs_apb_master.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfs_apb_master_pkg.sv
// Shared types and width limits for the APB initiator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
`ifndef CFS_APB_MAX_ADDR_WIDTH
`define CFS_APB_MAX_ADDR_WIDTH 32
`endif
`ifndef CFS_APB_MAX_DATA_WIDTH
`define CFS_APB_MAX_DATA_WIDTH 32
`endif

package cfs_apb_master_pkg;

  localparam int CFS_APB_MAX_ADDR_W = `CFS_APB_MAX_ADDR_WIDTH;
  localparam int CFS_APB_MAX_DATA_W = `CFS_APB_MAX_DATA_WIDTH;

  // Default widths used by the initiator and its bus interface.
  localparam int CFS_APB_MASTER_ADDR_WIDTH = 16;
  localparam int CFS_APB_MASTER_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } cfs_apb_master_state_t;

  // Response payload, sized for the widest supported data bus.
  typedef struct packed {
    logic [CFS_APB_MAX_DATA_W-1:0] rdata;
    logic                          err;
    logic                          timeout;
  } cfs_apb_master_rsp_t;

endpackage

// File: rtl/cfs_apb_master_if.sv
// APB3 bus bundle between the initiator (master) and a completer (slave).
// Latency: none, wires only; carries protocol checks on the bus.
// Backpressure: completer stalls the access phase by holding pready low.
// Ports: pclk, preset_n; signals paddr/pwrite/psel/penable/pwdata (master
// driven) and pready/prdata/pslverr (slave driven).
interface cfs_apb_master_if
  import cfs_apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = CFS_APB_MASTER_ADDR_WIDTH,
  parameter int DATA_WIDTH = CFS_APB_MASTER_DATA_WIDTH
) (
  input logic pclk,
  input logic preset_n
);

  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output pready, prdata, pslverr
  );

  // penable is only meaningful inside a selected transfer.
  a_enable_needs_sel: assert property (
    @(posedge pclk) disable iff (!preset_n) penable |-> psel);

  // A setup phase always moves into an access phase on the next cycle.
  a_setup_to_access: assert property (
    @(posedge pclk) disable iff (!preset_n)
    (psel && !penable) |=> (psel && penable));

  // Control and write data do not move between setup and access.
  a_setup_stable: assert property (
    @(posedge pclk) disable iff (!preset_n)
    (psel && !penable) |=> ($stable(paddr) && $stable(pwrite) && $stable(pwdata)));

  // Through wait states the transfer either stays put or is abandoned.
  a_wait_stable: assert property (
    @(posedge pclk) disable iff (!preset_n)
    (psel && penable && !pready) |=>
      (!psel || ($stable(paddr) && $stable(pwrite) && $stable(pwdata))));

endinterface

// File: rtl/cfs_apb_master_timer.sv
// Access-phase wait counter; flags the edge on which a transfer must be abandoned.
// Latency: expired is combinational from the registered count and enable.
// Backpressure: none; counts while enable is high, saturates, cleared by clear.
// Ports: pclk, preset_n, clear (restart), enable (slave still waiting),
// expired (this edge reaches TIMEOUT_CYCLES waiting cycles).
module cfs_apb_master_timer #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES > 0) begin : g_timer
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
        cnt <= '0;
      end else if (clear) begin
        cnt <= '0;
      end else if (enable && (cnt != CW'(TIMEOUT_CYCLES))) begin
        cnt <= cnt + CW'(1);
      end
    end

    // The count would reach TIMEOUT_CYCLES at this edge with the slave
    // still stalling.
    assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timer
    logic unused_tmr;
    assign unused_tmr = ^{pclk, preset_n, clear, enable};
    assign expired    = 1'b0;
  end

endmodule

// File: rtl/cfs_apb_master.sv
// APB3 initiator: turns one valid/ready request into one APB transfer and one response.
// Latency: accept at edge N -> setup N+1, access N+2, rsp_valid from N+3 (zero-wait slave).
// Backpressure: req_ready only in IDLE; rsp_* held while rsp_valid && !rsp_ready.
// Ports: pclk, preset_n; req_valid/req_ready/req_write/req_addr/req_wdata;
// rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout; apb (master modport).
module cfs_apb_master
  import cfs_apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = CFS_APB_MASTER_ADDR_WIDTH,
  parameter int DATA_WIDTH     = CFS_APB_MASTER_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  cfs_apb_master_if.master      apb
);

  cfs_apb_master_state_t state;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic                  psel_q;
  logic                  penable_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  cfs_apb_master_rsp_t   rsp_q;

  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;

  // Restart the wait count on the way into the access phase.
  assign tmr_clear  = (state == SETUP);
  assign tmr_enable = (state == ACCESS) && !apb.pready;

  cfs_apb_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .pclk    (pclk),
    .preset_n(preset_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state       <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr_q   <= req_addr;
            pwrite_q  <= req_write;
            // Reads leave pwdata alone so it never picks up stale/X data.
            if (req_write) begin
              pwdata_q <= req_wdata;
            end
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout landing on the same edge.
          if (apb.pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_q.rdata   <= pwrite_q ? '0 : CFS_APB_MAX_DATA_W'(apb.prdata);
            rsp_q.err     <= apb.pslverr;
            rsp_q.timeout <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end else if (tmr_expired) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready   = preset_n && (state == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwdata  = pwdata_q;

  if (DATA_WIDTH < CFS_APB_MAX_DATA_W) begin : g_rdata_hi
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^rsp_q.rdata[CFS_APB_MAX_DATA_W-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_cfs_apb_master.sv
// Self-checking bench for cfs_apb_master with a transaction-timeline model.
// Latency: n/a.
// Backpressure: bench drives random slave wait states and response stalls.
module tb_cfs_apb_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;

  cfs_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_if (
    .pclk(pclk), .preset_n(preset_n));

  cfs_apb_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb(apb_if.master)
  );

  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;

  // What the APB-side registers must hold: the last accepted request.
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [DW-1:0] m_pwdata;

  // Per-transaction observations, pinned against hand-computed literals.
  int            obs_psel_cycles;
  int            obs_first_rsp_k;
  logic [DW-1:0] obs_rdata;
  logic          obs_err;
  logic          obs_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bus_hold();
    chk("paddr",  64'(apb_if.paddr),  64'(m_addr));
    chk("pwrite", 64'(apb_if.pwrite), 64'(m_write));
    chk("pwdata", 64'(apb_if.pwdata), 64'(m_pwdata));
  endtask

  task automatic drive_junk();
    req_write       = 1'($urandom);
    req_addr        = AW'($urandom);
    req_wdata       = DW'($urandom);
    apb_if.pready   = 1'($urandom);
    apb_if.pslverr  = 1'($urandom);
    apb_if.prdata   = DW'($urandom);
  endtask

  // Idle cycles: nothing selected, ready for a request, bus fields held.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_psel",      64'(apb_if.psel),    64'(0));
      chk("idle_penable",   64'(apb_if.penable), 64'(0));
      chk("idle_req_ready", 64'(req_ready),      64'(1));
      chk("idle_rsp_valid", 64'(rsp_valid),      64'(0));
      chk_bus_hold();
      req_valid = 1'b0;
      rsp_ready = 1'($urandom);
      drive_junk();
      @(negedge pclk);
    end
  endtask

  // One transfer. w = access cycles with pready low before it rises (w >= TO
  // means the slave never answers), b = cycles of response stall.
  // Timeline in cycles after the request cycle k=0: setup at k=1, access
  // k=2..1+A, response from k=2+A, handshake at k=2+A+b.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int w, input logic err,
                         input logic [DW-1:0] rdata, input int b);
    bit            tmo;
    int            acc_n;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    tmo     = (w >= TO);
    acc_n   = tmo ? TO : w + 1;
    e_rdata = (tmo || wr) ? '0 : rdata;
    e_err   = tmo ? 1'b1 : err;
    obs_psel_cycles = 0;
    obs_first_rsp_k = -1;
    for (int k = 0; k <= 2 + acc_n + b; k++) begin
      chk("psel",      64'(apb_if.psel),    64'(k >= 1 && k <= 1 + acc_n));
      chk("penable",   64'(apb_if.penable), 64'(k >= 2 && k <= 1 + acc_n));
      chk("req_ready", 64'(req_ready),      64'(k == 0));
      chk("rsp_valid", 64'(rsp_valid),      64'(k >= 2 + acc_n));
      chk_bus_hold();
      if (k >= 2 + acc_n) begin
        chk("rsp_rdata",   64'(rsp_rdata),   64'(e_rdata));
        chk("rsp_err",     64'(rsp_err),     64'(e_err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(tmo));
      end
      if (apb_if.psel) obs_psel_cycles++;
      if (rsp_valid && obs_first_rsp_k < 0) obs_first_rsp_k = k;
      if (k == 2 + acc_n) begin
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
        obs_to    = rsp_timeout;
      end

      drive_junk();
      req_valid = (k == 0);
      if (k == 0) begin
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        m_addr    = addr;
        m_write   = wr;
        if (wr) m_pwdata = wdata;
      end
      if (k >= 2 && k <= 1 + acc_n) begin
        apb_if.pready = !tmo && (k == w + 2);
        if (k == w + 2) begin
          apb_if.pslverr = err;
          apb_if.prdata  = rdata;
        end
      end
      if (k >= 2 + acc_n) rsp_ready = (k == 2 + acc_n + b);
      else                rsp_ready = 1'($urandom);
      @(negedge pclk);
    end
    req_valid = 1'b0;
  endtask

  // Launch a read against a stalled slave and pull reset in its access phase.
  task automatic reset_mid_access();
    for (int k = 0; k < 4; k++) begin
      drive_junk();
      req_valid     = (k == 0);
      apb_if.pready = 1'b0;
      if (k == 0) begin
        req_write = 1'b0;
        req_addr  = 16'h0ABC;
        m_addr    = 16'h0ABC;
        m_write   = 1'b0;
      end
      @(negedge pclk);
    end
    chk("pre_rst_psel",    64'(apb_if.psel),    64'(1));
    chk("pre_rst_penable", 64'(apb_if.penable), 64'(1));
    #2;
    preset_n = 1'b0;
    #1;
    chk("rst_psel",      64'(apb_if.psel),    64'(0));
    chk("rst_penable",   64'(apb_if.penable), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid),      64'(0));
    chk("rst_paddr",     64'(apb_if.paddr),   64'(0));
    chk("rst_req_ready", 64'(req_ready),      64'(0));
    m_addr   = '0;
    m_write  = 1'b0;
    m_pwdata = '0;
    req_valid = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    #1;
    chk("rel_req_ready", 64'(req_ready), 64'(1));
    @(negedge pclk);
  endtask

  initial begin
    preset_n       = 1'b0;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    rsp_ready      = 1'b0;
    apb_if.pready  = 1'b0;
    apb_if.prdata  = '0;
    apb_if.pslverr = 1'b0;
    m_addr         = '0;
    m_write        = 1'b0;
    m_pwdata       = '0;

    #12;
    chk("reset_psel",        64'(apb_if.psel),    64'(0));
    chk("reset_penable",     64'(apb_if.penable), 64'(0));
    chk("reset_pwrite",      64'(apb_if.pwrite),  64'(0));
    chk("reset_paddr",       64'(apb_if.paddr),   64'(0));
    chk("reset_pwdata",      64'(apb_if.pwdata),  64'(0));
    chk("reset_rsp_valid",   64'(rsp_valid),      64'(0));
    chk("reset_rsp_rdata",   64'(rsp_rdata),      64'(0));
    chk("reset_rsp_err",     64'(rsp_err),        64'(0));
    chk("reset_rsp_timeout", 64'(rsp_timeout),    64'(0));
    @(negedge pclk);
    preset_n = 1'b1;
    #1;
    chk("reset_rel_req_ready", 64'(req_ready), 64'(1));
    @(negedge pclk);
    idle(2);

    // Zero-wait write.
    run_txn(1'b1, 16'h0010, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
    chk("wr_psel_cycles", 64'(obs_psel_cycles), 64'(2));
    chk("wr_rsp_latency", 64'(obs_first_rsp_k), 64'(3));
    chk("wr_rsp_err",     64'(obs_err),         64'(0));
    idle(1);

    // Read with three wait states; pwdata must still show the write data.
    run_txn(1'b0, 16'h0004, 32'h0BAD0BAD, 3, 1'b0, 32'h12345678, 0);
    chk("rd_rdata",       64'(obs_rdata),       64'(32'h12345678));
    chk("rd_psel_cycles", 64'(obs_psel_cycles), 64'(5));
    chk("rd_pwdata_kept", 64'(apb_if.pwdata),   64'(32'hDEADBEEF));

    // Slave error followed by five cycles of response stall, back to back.
    run_txn(1'b0, 16'h0020, 32'h0, 0, 1'b1, 32'h00C0FFEE, 5);
    chk("err_rsp_err", 64'(obs_err), 64'(1));
    chk("err_rsp_to",  64'(obs_to),  64'(0));

    // Slave never answers: abandon after eight access cycles.
    run_txn(1'b0, 16'h0030, 32'h0, 50, 1'b0, 32'hFFFFFFFF, 1);
    chk("to_psel_cycles", 64'(obs_psel_cycles), 64'(9));
    chk("to_rsp_latency", 64'(obs_first_rsp_k), 64'(10));
    chk("to_rsp_err",     64'(obs_err),         64'(1));
    chk("to_rsp_to",      64'(obs_to),          64'(1));
    chk("to_rsp_rdata",   64'(obs_rdata),       64'(0));
    idle(1);

    // pready rises on the eighth access cycle: completes normally.
    run_txn(1'b0, 16'h0040, 32'h0, 7, 1'b0, 32'hA5A50008, 0);
    chk("late_psel_cycles", 64'(obs_psel_cycles), 64'(9));
    chk("late_rsp_to",      64'(obs_to),          64'(0));
    chk("late_rsp_rdata",   64'(obs_rdata),       64'(32'hA5A50008));
    idle(1);

    reset_mid_access();
    idle(1);
    run_txn(1'b1, 16'h0050, 32'h55AA55AA, 1, 1'b0, 32'h0, 0);
    chk("post_rst_rsp_err", 64'(obs_err), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom), AW'($urandom), DW'($urandom),
              int'($urandom_range(0, 10)), 1'($urandom), DW'($urandom),
              int'($urandom_range(0, 4)));
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
